sram_req_arbiter: RTL
=====================

Name: sram_req_arbiter

Overview:
- Merges NUM_CH SRAM-like request/response channels onto one shared SRAM-like memory port. Channel 0 is instruction fetch and channel 1 is data in the base configuration.
- Sits between the pipeline stages (IF fetch, EX/MEM load-store) and the future single-bus bridge. It replaces the separate inst/data SRAM ports at the CPU top level.
- Uses round-robin arbitration with request locking. It tracks up to OUTSTANDING in-order transactions and routes each data_ok/rdata back to the issuing channel.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- OUTSTANDING, 4, depth of the in-flight channel-ID FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request valid.
- ch_wr  in  NUM_CH  1 = write, 0 = read.
- ch_size  in  2*NUM_CH  packed byte-size code (0 = 1 B, 1 = 2 B, 2 = 4 B).
- ch_addr  in  ADDR_W*NUM_CH  packed address.
- ch_wstrb  in  (DATA_W/8)*NUM_CH  packed byte strobes.
- ch_wdata  in  DATA_W*NUM_CH  packed write data.
- ch_addr_ok  out  NUM_CH  request accepted this cycle.
- ch_data_ok  out  NUM_CH  response (read data or write ack) this cycle.
- ch_rdata  out  DATA_W  read data, broadcast to all channels.
- mem_req  out  1  shared request valid.
- mem_wr  out  1  shared write flag.
- mem_size  out  2  shared size code.
- mem_addr  out  ADDR_W  shared address.
- mem_wstrb  out  DATA_W/8  shared strobes.
- mem_wdata  out  DATA_W  shared write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory returns a response (in order).
- mem_rdata  in  DATA_W  memory read data.
- resp_err  out  1  sticky: mem_data_ok arrived with no transaction outstanding.

Behaviour:
- Reset values: all outputs 0. Lock invalid, rr_ptr = 0, FIFO empty (head = tail = 0, count = 0), resp_err = 0.
- Grant selection:
  - Lock invalid: grant = first channel with ch_req set, searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - Lock valid: grant = the locked channel.
- Shared request:
  - mem_req = ch_req[grant] & (count != OUTSTANDING). The mem_* payload fields are muxed from grant.
  - When the FIFO is full, mem_req = 0 and no ch_addr_ok is asserted.
- Lock:
  - Set (with the channel index) when mem_req = 1 and mem_addr_ok = 0.
  - Cleared on the accept cycle.
  - The request stays stable to memory until accepted, even if a higher-priority channel asserts meanwhile.
- Accept:
  - An accept is mem_req & mem_addr_ok. It drives ch_addr_ok[grant] = 1, combinationally in the same cycle.
  - On accept: push grant into the FIFO and set rr_ptr = (grant+1) mod NUM_CH.
- Response:
  - ch_data_ok[fifo[head]] = mem_data_ok & (count != 0).
  - ch_rdata = mem_rdata. There is zero-cycle pass-through.
  - The FIFO is popped on the response.
- Push and pop in the same cycle: count is unchanged; head and tail both advance, wrapping modulo OUTSTANDING.
- Pop with the FIFO full in the same cycle as a new request: mem_req stays 0 this cycle, because fullness is based on registered count. The request issues on the next cycle.
- mem_data_ok with count = 0: ignored. No ch_data_ok is asserted. resp_err is set and held until reset.
- A channel dropping ch_req while locked is a protocol violation. The lock is held regardless, and mem_req falls. Checked by an assertion in the bench.
- Reset mid-operation: the FIFO, lock and rr_ptr are cleared. Late mem_data_ok pulses after reset set resp_err.
- NUM_CH = 1: the arbiter degenerates to a pass-through with ID tracking only. rr_ptr stays 0.

Decomposition:
- Shared package (mycpu_bus_pkg): size-code constants (SIZE_B=0, SIZE_H=1, SIZE_W=2) and the default NUM_CH/OUTSTANDING values.
- Sub-module id_fifo: synchronous FIFO with parameters WIDTH = clog2(NUM_CH) (minimum 1) and DEPTH = OUTSTANDING, exposing full/empty/count.

Test Plan:
- Single read: ch0 reads addr 0x1C000000, mem_addr_ok the same cycle, mem_data_ok 2 cycles later with rdata 0xDEADBEEF → ch_addr_ok[0] in cycle 0, ch_data_ok[0] in cycle 2 with ch_rdata = 0xDEADBEEF, ch_data_ok[1] = 0.
- Contention: ch0 and ch1 request continuously, mem_addr_ok always 1 → grants alternate 0,1,0,1. mem_addr shows both addresses interleaved.
- Lock: ch1 requests, mem_addr_ok held 0 for 3 cycles while ch0 also requests → mem_addr stays ch1's address for all 4 cycles. ch_addr_ok[1] asserts in cycle 3, then ch0 is granted.
- Full: 4 accepted reads with no data_ok → mem_req = 0 on the 5th request. One mem_data_ok pops ch0's entry; the next cycle mem_req = 1.
- Out-of-band response: mem_data_ok with an empty FIFO → no ch_data_ok, resp_err = 1 and held. After reset, resp_err = 0.
- Mid-operation reset: 2 transactions outstanding, reset pulsed for 1 cycle → count = 0 and rr_ptr = 0. A subsequent mem_data_ok sets resp_err.

Source files
------------

// File: rtl/mycpu_bus_pkg.sv
// Shared bus definitions for the CPU-side SRAM-like interfaces.
// Provides size codes, default arbiter sizing and the lock FSM state type.
package mycpu_bus_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_OUTSTANDING = 4;

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_LOCK = 1'b1
  } lock_st_e;

  // Channel-ID width; a single channel still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of channel IDs for transactions awaiting a response.
// Ports: clk/reset, i_push/i_din, i_pop/o_dout, o_full, o_empty, o_count.
module id_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_head];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_din;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (~w_push & w_pop)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter merging NUM_CH SRAM-like channels onto one port.
// Ports: ch_* per-channel requests/responses, mem_* shared port, resp_err.
module sram_req_arbiter
  import mycpu_bus_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = DEF_OUTSTANDING
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [DATA_W/8*NUM_CH-1:0] ch_wstrb,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       resp_err
);

  localparam int CW = id_w(NUM_CH);
  localparam int SW = DATA_W / 8;
  localparam int FW = $clog2(OUTSTANDING) + 1;

  lock_st_e      r_state;
  lock_st_e      w_state_nxt;
  logic [CW-1:0] r_lock_ch;
  logic [CW-1:0] r_rr_ptr;
  logic [CW-1:0] w_search;
  logic [CW-1:0] w_grant;
  logic [CW-1:0] w_head_id;
  logic [FW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_greq;
  logic          w_accept;
  logic          w_stall;
  logic          w_rsp;
  logic          r_resp_err;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic found;
    found    = 1'b0;
    w_search = r_rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_req[CW'(idx)]) begin
        found    = 1'b1;
        w_search = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FREE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall) r_lock_ch <= w_grant;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FREE: if (w_stall)  w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_accept) w_state_nxt = ST_FREE;
      default: w_state_nxt = ST_FREE;
    endcase
  end

  // A locked channel keeps the port even if it drops its request.
  always_comb begin
    w_grant = (r_state == ST_LOCK) ? r_lock_ch : w_search;
  end

  always_comb begin
    w_greq    = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == CW'(i)) begin
        w_greq    = ch_req[i];
        mem_wr    = ch_wr[i];
        mem_size  = ch_size[2*i +: 2];
        mem_addr  = ch_addr[ADDR_W*i +: ADDR_W];
        mem_wstrb = ch_wstrb[SW*i +: SW];
        mem_wdata = ch_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Fullness uses the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign mem_req  = w_greq & ~w_full;
  assign w_accept = mem_req & mem_addr_ok;
  assign w_stall  = mem_req & ~mem_addr_ok;
  assign w_rsp    = mem_data_ok & (w_count != '0);

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr_ok[i] = w_accept & (w_grant == CW'(i));
      ch_data_ok[i] = w_rsp & (w_head_id == CW'(i));
    end
  end

  assign ch_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      if (w_grant == CW'(NUM_CH - 1))
        r_rr_ptr <= '0;
      else
        r_rr_ptr <= w_grant + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_resp_err <= 1'b0;
    else if (mem_data_ok & w_empty)
      r_resp_err <= 1'b1;
  end

  assign resp_err = r_resp_err;

  id_fifo #(
    .WIDTH (CW),
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_grant),
    .i_pop   (mem_data_ok),
    .o_dout  (w_head_id),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
